// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the asynchronous FIFO's single write port
// between NUM_REQ requesters in the wclk domain. Each grant lasts for at most BURST_LEN words.
// Requesters see a valid/ready handshake. The FIFO side is driven through winc/wdata and is
// throttled by wfull.
//
// Ports:
//   wclk       write-domain clock (rising edge)
//   wrst_n     synchronous active-low reset
//   req_valid  per-requester word-present flags
//   req_data   flattened requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept strobes (only the owner can be high)
//   wfull      FIFO full flag, already in the wclk domain
//   winc       FIFO write enable
//   wdata      FIFO write data (0 when no grant is held)
//   grant_id   index of the current/last owner
//   busy       high while a grant is held
//   stall_cnt  saturating count of owner-valid cycles blocked by wfull
//              (present only when FIFO_WR_ARB_STALL_CNT_EN is defined)
//
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4,
    localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned BW        = $clog2(BURST_LEN + 1)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [GW-1:0]                 grant_id,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic            any_valid;
    logic [GW-1:0]   rr_winner;
    logic            owner_valid;
    logic            beat;

    // Round-robin search: first valid requester at or above last_grant+1, wrapping.
    always_comb begin
        logic found;
        found     = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int idx;
            idx = (int'(last_q) + k) % int'(NUM_REQ);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                rr_winner = GW'(idx);
            end
        end
        any_valid = |req_valid;
    end

    assign owner_valid = req_valid[grant_q];
    assign busy        = (state_q == StGrant);
    assign grant_id    = grant_q;

    // winc/req_ready are also gated by wrst_n so the word on the bus during a reset edge
    // is never written into the FIFO.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        if (busy) begin
            req_ready[grant_q] = ~wfull & wrst_n;
            winc               = owner_valid & ~wfull & wrst_n;
            wdata              = req_data[int'(grant_q)*int'(DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    // A transfer for next-state purposes ignores the wrst_n gate; reset overrides anyway.
    assign beat = busy & owner_valid & ~wfull;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StGrant;
                    grant_d = rr_winner;
                    last_d  = rr_winner;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                if (beat) begin
                    beat_d = beat_q + BW'(1);
                end
                if ((beat && (beat_q == BW'(BURST_LEN - 1))) || !owner_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            stall_q <= '0;
        end else if (busy && owner_valid && wfull && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter. A behavioural model of the grant
// policy (round-robin search with modulo arithmetic, burst/beat bookkeeping in plain ints)
// predicts every output each cycle; several stimulus phases bias the random traffic toward
// single-requester, saturated round-robin, heavy back-pressure and reset-heavy scenarios.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;
    localparam int GW = 2;
    localparam int CYCLES_PER_PHASE = 400;

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [GW-1:0]     grant_id;
    logic              busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model state
    bit m_granted;
    int m_owner;
    int m_last;
    int m_beats;
    int m_stall;
    int m_grant_words;

    // Requester-side stimulus state
    bit          v   [NR];
    logic [DW-1:0] d [NR];

    // Phase knobs (percentages)
    int p_raise, p_drop, p_full, p_rst;
    logic [NR-1:0] mask;

    function automatic int rr_pick(input int last, input bit vv [NR]);
        for (int k = 1; k <= NR; k++) begin
            if (vv[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_granted     = 0;
        m_owner       = 0;
        m_last        = NR - 1;
        m_beats       = 0;
        m_stall       = 0;
        m_grant_words = 0;
    endtask

    task automatic run_cycle(input bit force_rst);
        bit rst_n;
        bit full;
        bit exp_winc;
        bit any;
        logic [NR-1:0] exp_ready;
        logic [DW-1:0] exp_wdata;
        bit acc [NR];

        @(negedge wclk);
        rst_n = force_rst ? 1'b0 : !($urandom_range(99) < p_rst);
        full  = ($urandom_range(99) < p_full);
        wrst_n = rst_n;
        wfull  = full;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = v[i];
            req_data[i*DW +: DW]    = d[i];
        end
        #1;

        exp_winc  = m_granted && v[m_owner] && !full && rst_n;
        exp_ready = '0;
        if (m_granted && !full && rst_n) exp_ready[m_owner] = 1'b1;
        exp_wdata = m_granted ? d[m_owner] : '0;

        check("winc",      32'(winc),      32'(exp_winc));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("wdata",     32'(wdata),     32'(exp_wdata));
        check("busy",      32'(busy),      32'(m_granted));
        check("grant_id",  32'(grant_id),  32'(m_owner));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

        for (int i = 0; i < NR; i++) acc[i] = exp_winc && (i == m_owner);

        @(posedge wclk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_granted) begin
            any = 0;
            for (int i = 0; i < NR; i++) any |= v[i];
            if (any) begin
                m_owner       = rr_pick(m_last, v);
                m_last        = m_owner;
                m_beats       = 0;
                m_granted     = 1;
                m_grant_words = 0;
            end
        end else begin
            if (v[m_owner] && full && m_stall < 65535) m_stall++;
            if (exp_winc) begin
                m_beats++;
                if (m_beats == BL) m_granted = 0;
            end
            if (!v[m_owner]) m_granted = 0;
        end

        // Requesters hold a word until it is accepted, then move on or go quiet.
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                if ($urandom_range(99) < p_drop) v[i] = 0;
                else d[i] = DW'($urandom);
            end else if (!v[i] && mask[i] && ($urandom_range(99) < p_raise)) begin
                v[i] = 1;
                d[i] = DW'($urandom);
            end
        end
    endtask

    task automatic set_phase(input logic [NR-1:0] m, input int raise, input int drop,
                             input int fullp, input int rstp);
        mask = m; p_raise = raise; p_drop = drop; p_full = fullp; p_rst = rstp;
    endtask

    initial begin
        wrst_n    = 1'b0;
        wfull     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            v[i] = 0;
            d[i] = '0;
        end
        model_reset();

        // Reset state, with no traffic
        set_phase(4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0);

        // Single requester, occasional drops
        set_phase(4'b0001, 100, 15, 0, 0);
        for (int i = 0; i < CYCLES_PER_PHASE; i++) run_cycle(1'b0);

        // Saturated round-robin, no back-pressure
        set_phase(4'b1111, 100, 0, 0, 0);
        for (int i = 0; i < CYCLES_PER_PHASE; i++) run_cycle(1'b0);

        // Heavy back-pressure
        set_phase(4'b1111, 60, 20, 50, 0);
        for (int i = 0; i < CYCLES_PER_PHASE; i++) run_cycle(1'b0);

        // Non-owner isolation mix: requesters 1 and 3 only
        set_phase(4'b1010, 80, 30, 20, 0);
        for (int i = 0; i < CYCLES_PER_PHASE; i++) run_cycle(1'b0);

        // Everything random, including mid-burst resets
        set_phase(4'b1111, 40, 40, 25, 3);
        for (int i = 0; i < CYCLES_PER_PHASE; i++) run_cycle(1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
